// File: rtl/reset_conditioner.sv
// Reset request conditioner: merges power-on hold, PLL lock and a debounced pushbutton
// into one glitch-free, minimum-width active-low reset, and keeps reset-cause history.
module reset_conditioner #(
   parameter int POR_CYCLES       = 1024,
   parameter int DEBOUNCE_CYCLES  = 65536,
   parameter int MIN_PULSE_CYCLES = 256
) (
   input  logic       clk,
   input  logic       rst_async_n,
   input  logic       btn_n,
   input  logic       pll_locked,
   output logic       sys_rst_n,
   output logic [1:0] rst_cause,
   output logic [7:0] rst_count
);

   localparam int CNT_MAX = (POR_CYCLES > MIN_PULSE_CYCLES) ? POR_CYCLES : MIN_PULSE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);

   localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(MIN_PULSE_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_LOCK = 2'b01;
   localparam logic [1:0] CAUSE_BTN  = 2'b10;

   typedef enum logic [1:0] {ST_POR, ST_WAIT, ST_RUN, ST_STRETCH} state_t;

   logic [1:0]       btn_sync_q;
   logic [1:0]       lock_sync_q;
   logic             btn_s;
   logic             lock_s;
   logic             btn_db_q, btn_db_d;
   logic             btn_db_prev_q;
   logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic             press;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sys_rst_n_q, sys_rst_n_d;
   logic [1:0]       cause_q, cause_d;
   logic [7:0]       count_q, count_d;

   // Button chain resets to "released", lock chain to "unlocked".
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         btn_sync_q  <= 2'b11;
         lock_sync_q <= 2'b00;
      end else begin
         btn_sync_q  <= {btn_sync_q[0], btn_n};
         lock_sync_q <= {lock_sync_q[0], pll_locked};
      end
   end

   assign btn_s  = btn_sync_q[1];
   assign lock_s = lock_sync_q[1];

   always_comb begin
      db_cnt_d = '0;
      btn_db_d = btn_db_q;
      if (btn_s != btn_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_db_d = btn_s;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   assign press = btn_db_prev_q & ~btn_db_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      count_d = count_q;
      case (state_q)
         ST_POR: begin
            if (cnt_q == POR_LAST) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT: begin
            if (lock_s && btn_db_q) state_d = ST_RUN;
         end
         ST_RUN: begin
            // Lock loss wins over a simultaneous press; only one event is counted.
            if (!lock_s || press) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
               cause_d = !lock_s ? CAUSE_LOCK : CAUSE_BTN;
               if (count_q != 8'hFF) count_d = count_q + 8'd1;
            end
         end
         ST_STRETCH: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_POR;
            cnt_d   = '0;
         end
      endcase
      sys_rst_n_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         state_q       <= ST_POR;
         cnt_q         <= '0;
         btn_db_q      <= 1'b1;
         btn_db_prev_q <= 1'b1;
         db_cnt_q      <= '0;
         sys_rst_n_q   <= 1'b0;
         cause_q       <= CAUSE_POR;
         count_q       <= 8'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         btn_db_q      <= btn_db_d;
         btn_db_prev_q <= btn_db_q;
         db_cnt_q      <= db_cnt_d;
         sys_rst_n_q   <= sys_rst_n_d;
         cause_q       <= cause_d;
         count_q       <= count_d;
      end
   end

   assign sys_rst_n = sys_rst_n_q;
   assign rst_cause = cause_q;
   assign rst_count = count_q;

endmodule

// File: tb/tb_reset_conditioner.sv
// Bench for reset_conditioner: directed sequences, a table of pulse vectors and a
// randomized run checked against a deadline-based reference model.
module tb_reset_conditioner;

   localparam int POR = 16;
   localparam int MIN = 8;
   localparam int DEB = 8;

   logic       clk = 1'b0;
   logic       rst_async_n = 1'b0;
   logic       btn_n = 1'b1;
   logic       pll_locked = 1'b1;
   logic       sys_rst_n;
   logic [1:0] rst_cause;
   logic [7:0] rst_count;

   reset_conditioner #(
      .POR_CYCLES      (POR),
      .DEBOUNCE_CYCLES (DEB),
      .MIN_PULSE_CYCLES(MIN)
   ) dut (
      .clk        (clk),
      .rst_async_n(rst_async_n),
      .btn_n      (btn_n),
      .pll_locked (pll_locked),
      .sys_rst_n  (sys_rst_n),
      .rst_cause  (rst_cause),
      .rst_count  (rst_count)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         exp_count = 0;
   logic [1:0] exp_cause = 2'b00;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: reset stays asserted until an "earliest release" edge has
   // passed and the synchronized lock and debounced button are both good.
   bit         m_up = 1'b0;
   int         m_n = 0;
   int         m_earliest = POR + 1;
   logic [1:0] m_cause = 2'b00;
   int         m_count = 0;
   bit         m_lq[2];
   bit         m_bq[2];
   bit         m_hist[$];
   bit         m_db = 1'b1;
   bit         m_db_prev = 1'b1;
   bit         model_chk = 1'b0;

   task automatic model_reset();
      m_n = 0; m_up = 0; m_earliest = POR + 1; m_cause = 2'b00; m_count = 0;
      m_lq[0] = 0; m_lq[1] = 0; m_bq[0] = 1; m_bq[1] = 1;
      m_hist.delete(); m_db = 1; m_db_prev = 1;
   endtask

   task automatic model_step();
      bit ls, bs, press, all_diff;
      m_n++;
      ls = m_lq[0];
      bs = m_bq[0];
      press = m_db_prev && !m_db;
      if (m_up) begin
         if (!ls || press) begin
            m_up = 0;
            m_cause = !ls ? 2'b01 : 2'b10;
            m_count = (m_count >= 255) ? 255 : m_count + 1;
            m_earliest = m_n + MIN + 1;
         end
      end else if (m_n >= m_earliest && ls && m_db) begin
         m_up = 1;
      end
      // Button accepted once the last DEB synchronized samples all disagree with it.
      m_hist.push_back(bs);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      m_db_prev = m_db;
      if (m_hist.size() == DEB) begin
         all_diff = 1;
         foreach (m_hist[i]) if (m_hist[i] == m_db) all_diff = 0;
         if (all_diff) m_db = bs;
      end
      m_lq[0] = m_lq[1]; m_lq[1] = pll_locked;
      m_bq[0] = m_bq[1]; m_bq[1] = btn_n;
   endtask

   always @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (model_chk) begin
         check("model_sys_rst_n", sys_rst_n, m_up);
         check("model_cause", rst_cause, m_cause);
         check("model_count", rst_count, m_count);
      end
   end

   task automatic wait_run(input int budget);
      int k = 0;
      while (sys_rst_n !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("wait_run", sys_rst_n, 1);
   endtask

   task automatic por_seq(input string tag);
      bit early = 0;
      @(negedge clk);
      rst_async_n = 1'b1;
      for (int e = 1; e <= POR; e++) begin
         @(negedge clk);
         if (sys_rst_n !== 1'b0) early = 1;
      end
      check({tag, "_hold"}, early, 0);
      @(negedge clk);
      check({tag, "_release"}, sys_rst_n, 1);
      check({tag, "_cause"}, rst_cause, 0);
      check({tag, "_count"}, rst_count, 0);
      $display("%s: sys_rst_n=%0d after edge %0d cause=%0d count=%0d", tag, sys_rst_n, POR + 1, rst_cause, rst_count);
   endtask

   typedef struct {
      int         lock_low;
      int         btn_low;
      bit         exp_event;
      logic [1:0] exp_cause;
   } vec_t;

   initial begin
      int   k, low_len, mx, lock_left, btn_left;
      bit   saw;
      vec_t vecs[7];

      vecs[0] = '{1, 0, 1'b1, 2'b01};
      vecs[1] = '{0, 3, 1'b0, 2'b00};
      vecs[2] = '{0, 7, 1'b0, 2'b00};
      vecs[3] = '{0, 8, 1'b1, 2'b10};
      vecs[4] = '{4, 0, 1'b1, 2'b01};
      vecs[5] = '{0, 12, 1'b1, 2'b10};
      vecs[6] = '{0, 1, 1'b0, 2'b00};

      rst_async_n = 1'b0; btn_n = 1'b1; pll_locked = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_sys_rst_n", sys_rst_n, 0);
      check("reset_cause", rst_cause, 0);
      check("reset_count", rst_count, 0);
      $display("reset: sys_rst_n=%0d cause=%0d count=%0d", sys_rst_n, rst_cause, rst_count);

      por_seq("por1");
      exp_count = 0; exp_cause = 2'b00;

      // Lock loss of 3 cycles: fall on edge 3, low for MIN stretch plus one WAIT cycle.
      wait_run(100);
      @(negedge clk); pll_locked = 1'b0;
      @(negedge clk); @(negedge clk);
      check("lock_fall_not_early", sys_rst_n, 1);
      @(negedge clk);
      check("lock_fall_edge3", sys_rst_n, 0);
      pll_locked = 1'b1;
      low_len = 1; k = 0;
      while (sys_rst_n === 1'b0 && k < 50) begin
         @(negedge clk);
         k++;
         if (sys_rst_n === 1'b0) low_len++;
      end
      check("lock_low_len", low_len, MIN + 1);
      exp_count++; exp_cause = 2'b01;
      check("lock_cause", rst_cause, exp_cause);
      check("lock_count", rst_count, exp_count);
      $display("lock loss: low_len=%0d cause=%0d count=%0d", low_len, rst_cause, rst_count);

      // Bounces shorter than DEB, then a 30-cycle hold and release.
      wait_run(100);
      saw = 0;
      repeat (6) begin
         btn_n = 1'b0;
         repeat ($urandom_range(1, 5)) begin @(negedge clk); if (sys_rst_n !== 1'b1) saw = 1; end
         btn_n = 1'b1;
         repeat ($urandom_range(1, 5)) begin @(negedge clk); if (sys_rst_n !== 1'b1) saw = 1; end
      end
      repeat (DEB + 4) begin @(negedge clk); if (sys_rst_n !== 1'b1) saw = 1; end
      check("bounce_no_reset", saw, 0);
      check("bounce_count", rst_count, exp_count);
      btn_n = 1'b0;
      repeat (30) @(negedge clk);
      check("btn_hold_low", sys_rst_n, 0);
      btn_n = 1'b1;
      k = 0;
      while (sys_rst_n !== 1'b1 && k < 60) begin @(negedge clk); k++; end
      check("btn_release_latency", k, DEB + 3);
      exp_count++; exp_cause = 2'b10;
      check("btn_cause", rst_cause, exp_cause);
      check("btn_count", rst_count, exp_count);
      $display("button hold: release_latency=%0d cause=%0d count=%0d", k, rst_cause, rst_count);

      // Table of single pulses applied from RUN.
      foreach (vecs[v]) begin
         wait_run(300);
         mx = (vecs[v].lock_low > vecs[v].btn_low) ? vecs[v].lock_low : vecs[v].btn_low;
         saw = 0;
         for (int c = 0; c < mx; c++) begin
            pll_locked = (c >= vecs[v].lock_low);
            btn_n = (c >= vecs[v].btn_low);
            @(negedge clk);
            if (sys_rst_n !== 1'b1) saw = 1;
         end
         pll_locked = 1'b1; btn_n = 1'b1;
         repeat (DEB + 20) begin @(negedge clk); if (sys_rst_n !== 1'b1) saw = 1; end
         wait_run(300);
         if (vecs[v].exp_event) begin
            exp_count++;
            exp_cause = vecs[v].exp_cause;
         end
         check($sformatf("vec%0d_event", v), saw, vecs[v].exp_event);
         check($sformatf("vec%0d_cause", v), rst_cause, exp_cause);
         check($sformatf("vec%0d_count", v), rst_count, exp_count);
         $display("vec%0d: lock_low=%0d btn_low=%0d reset_seen=%0d cause=%0d count=%0d",
                  v, vecs[v].lock_low, vecs[v].btn_low, saw, rst_cause, rst_count);
      end

      // Lock loss and a debounced press land on the same edge.
      wait_run(100);
      @(negedge clk); btn_n = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk); pll_locked = 1'b0;
      repeat (2) @(negedge clk);
      pll_locked = 1'b1;
      repeat (5) @(negedge clk);
      btn_n = 1'b1;
      repeat (5) @(negedge clk);
      wait_run(200);
      exp_count++; exp_cause = 2'b01;
      check("simul_cause", rst_cause, exp_cause);
      check("simul_count", rst_count, exp_count);
      $display("simultaneous: cause=%0d count=%0d", rst_cause, rst_count);

      // Randomized traffic checked cycle by cycle against the model.
      model_chk = 1'b1;
      lock_left = 0; btn_left = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (lock_left > 0) lock_left--;
         else if ($urandom_range(0, 99) < 1) lock_left = $urandom_range(1, 4);
         if (btn_left > 0) btn_left--;
         else if ($urandom_range(0, 99) < 3) btn_left = $urandom_range(1, 20);
         pll_locked = (lock_left == 0);
         btn_n = (btn_left == 0);
      end
      @(negedge clk);
      pll_locked = 1'b1; btn_n = 1'b1;
      repeat (DEB + 20) @(negedge clk);
      model_chk = 1'b0;
      exp_count = m_count; exp_cause = m_cause;
      $display("random: model count=%0d cause=%0d, dut count=%0d cause=%0d", m_count, m_cause, rst_count, rst_cause);

      // 260 lock-loss events: the counter must stick at 255.
      for (int i = 0; i < 260; i++) begin
         wait_run(100);
         @(negedge clk); pll_locked = 1'b0;
         @(negedge clk); pll_locked = 1'b1;
         repeat (3) @(negedge clk);
      end
      wait_run(100);
      exp_count = (exp_count + 260 > 255) ? 255 : exp_count + 260;
      check("saturate_count", rst_count, exp_count);
      check("saturate_cause", rst_cause, 2'b01);
      $display("saturation: count=%0d", rst_count);

      // Async reset while stretching clears history and replays the POR sequence.
      wait_run(100);
      @(negedge clk); pll_locked = 1'b0;
      repeat (4) @(negedge clk);
      check("stretch_entered", sys_rst_n, 0);
      pll_locked = 1'b1;
      #2 rst_async_n = 1'b0;
      #1;
      check("stretch_rst_sys_rst_n", sys_rst_n, 0);
      check("stretch_rst_cause", rst_cause, 0);
      check("stretch_rst_count", rst_count, 0);
      $display("reset in stretch: sys_rst_n=%0d cause=%0d count=%0d", sys_rst_n, rst_cause, rst_count);
      por_seq("por2");

      // Async reset in RUN drops the request without waiting for a clock edge.
      #2 rst_async_n = 1'b0;
      #1;
      check("run_rst_sys_rst_n", sys_rst_n, 0);
      $display("reset in run: sys_rst_n=%0d", sys_rst_n);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
